hex_display_scanner: RTL

- Time-multiplexed controller for a common-segment seven-segment display bank.
- Holds a NUM_DIGITS-nibble display value and shares one nibble→segment decoder across all digit positions.
- Scans the digits with a blanking gap between them to prevent ghosting.
- Accepts new values via a load/ready handshake and commits them only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/hex_display_pkg.sv | 12 +
 rtl/hex_display_scanner_hexdriver.sv | 32 +++
 rtl/hex_display_scanner.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package hex_display_pkg;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_t;

    // Active-low segments, so all ones is dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex_display_scanner_hexdriver.sv
// HexDriver: nibble to active-low {g,f,e,d,c,b,a} seven-segment decoder.
module HexDriver
    import hex_display_pkg::*;
(
    input  logic [3:0] binary_in,
    output logic [6:0] seven_segment_out
);

    always_comb begin
        seven_segment_out = SEG_OFF;
        unique case (binary_in)
            4'h0: seven_segment_out = 7'b1000000;
            4'h1: seven_segment_out = 7'b1111001;
            4'h2: seven_segment_out = 7'b0100100;
            4'h3: seven_segment_out = 7'b0110000;
            4'h4: seven_segment_out = 7'b0011001;
            4'h5: seven_segment_out = 7'b0010010;
            4'h6: seven_segment_out = 7'b0000010;
            4'h7: seven_segment_out = 7'b1111000;
            4'h8: seven_segment_out = 7'b0000000;
            4'h9: seven_segment_out = 7'b0010000;
            4'hA: seven_segment_out = 7'b0001000;
            4'hB: seven_segment_out = 7'b0000011;
            4'hC: seven_segment_out = 7'b1000110;
            4'hD: seven_segment_out = 7'b0100001;
            4'hE: seven_segment_out = 7'b0000110;
            4'hF: seven_segment_out = 7'b0001110;
            default: seven_segment_out = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed seven-segment scanner with frame-aligned value commit.
// Optional leading-zero suppression: define HEX_SCAN_LEADING_ZERO_BLANK_EN.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SHOW_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic                    ready,
    input  logic                    blank_in,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic [6:0]              segment_n
);

    localparam int unsigned MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      frame_end;
    logic [4*NUM_DIGITS-1:0]   display_q, shadow_q;
    logic                      pending_q;
    logic [NUM_DIGITS-1:0]     digit_en_q, digit_en_d;
    logic [6:0]                segment_q, segment_d;
    logic [3:0]                nibble;
    logic [6:0]                seg_dec;
    logic                      suppress;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        frame_end = 1'b0;
        unique case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    assign nibble = display_q[4*idx_q +: 4];

    HexDriver u_decoder (
        .binary_in         (nibble),
        .seven_segment_out (seg_dec)
    );

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;

    // lz_mask[k] is set when nibble k and every higher nibble are zero; digit 0 never masks.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (display_q[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_above;
        end
    end

    assign suppress = lz_mask[idx_q];
`else
    assign suppress = 1'b0;
`endif

    // Outputs follow the next state so they switch on the edge that enters or leaves S_SHOW.
    always_comb begin
        digit_en_d = '1;
        segment_d  = SEG_OFF;
        if (state_d == S_SHOW && !blank_in && !suppress) begin
            digit_en_d[idx_q] = 1'b0;
            segment_d         = seg_dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            display_q  <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            digit_en_q <= '1;
            segment_q  <= SEG_OFF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            digit_en_q <= digit_en_d;
            segment_q  <= segment_d;
            // Load and commit are exclusive: a load needs !pending, a commit needs pending.
            if (load && !pending_q) begin
                shadow_q  <= value_in;
                pending_q <= 1'b1;
            end else if (frame_end && pending_q) begin
                display_q <= shadow_q;
                pending_q <= 1'b0;
            end
        end
    end

    assign ready      = ~pending_q;
    assign digit_en_n = digit_en_q;
    assign segment_n  = segment_q;

endmodule
